// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle signed multiply/divide engine for the CPU datapath.
// MUL uses radix-4 (bit-pair) Booth recoding, 16 steps.
// DIV uses non-restoring division on operand magnitudes, 32 steps, followed by
// one fix-up cycle that restores the remainder and applies the signs.
//
// Handshake: start is sampled only in IDLE, and the operands and op are
// captured at that edge. busy is high from that edge until the edge that
// enters DONE. done is high for exactly the DONE cycle, and busy is low then.
// Any start seen while busy or in DONE is dropped, not queued.
// result_hi/result_lo change only on entry to DONE.
module mul_div_unit #(
    parameter int WIDTH     = 32,
    parameter int MUL_ITERS = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic [2:0]       dbg_state
);

    localparam int PW = 2 * WIDTH + 2;     // Booth accumulator width
    localparam int RW = WIDTH + 2;         // signed partial remainder width
    localparam int CW = $clog2(WIDTH + 1); // iteration counter width

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_DFIX = 3'd3;
    localparam logic [2:0] S_DZ   = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]       state;
    logic [CW-1:0]    cnt;

    // Multiply datapath
    logic [PW-1:0]    prod;
    logic [PW-1:0]    m_sh;
    logic [PW-1:0]    pp;
    logic [WIDTH-1:0] mq;
    logic             mq_prev;

    // Divide datapath
    logic [RW-1:0]    rem_r;
    logic [RW-1:0]    dvs;
    logic [RW-1:0]    r_sh;
    logic [RW-1:0]    r_next;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] rem_mag;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_reg;
    logic             dz_r;

    logic             accept;
    logic             mul_step;
    logic             mul_last;
    logic             div_step;
    logic             dz_last;

    assign accept   = (state == S_IDLE) && start;
    assign mul_last = (state == S_MUL) && (cnt == CW'(MUL_ITERS));
    assign mul_step = (state == S_MUL) && (cnt != CW'(MUL_ITERS));
    assign div_step = (state == S_DIV) && (cnt != CW'(WIDTH));
    assign dz_last  = (state == S_DZ) && (cnt == CW'(1));

    assign busy        = (state != S_IDLE) && (state != S_DONE);
    assign done        = (state == S_DONE);
    assign div_by_zero = dz_r;
    assign dbg_state   = state;

    assign a_mag = a_in[WIDTH-1] ? (~a_in + 1'b1) : a_in;
    assign b_mag = b_in[WIDTH-1] ? (~b_in + 1'b1) : b_in;

    // Booth bit-pair recoding: {b[2i+1], b[2i], b[2i-1]} selects 0, +-A, +-2A
    always_comb begin
        pp = '0;
        case ({mq[1:0], mq_prev})
            3'b001, 3'b010: pp = m_sh;
            3'b011:         pp = m_sh << 1;
            3'b100:         pp = -(m_sh << 1);
            3'b101, 3'b110: pp = -m_sh;
            default:        pp = '0;
        endcase
    end

    // Non-restoring step plus the final remainder restore and sign correction
    always_comb begin
        r_sh     = {rem_r[RW-2:0], quo_r[WIDTH-1]};
        r_next   = rem_r[RW-1] ? (r_sh + dvs) : (r_sh - dvs);
        q_next   = {quo_r[WIDTH-2:0], ~r_next[RW-1]};
        rem_mag  = rem_r[RW-1] ? (rem_r[WIDTH-1:0] + dvs[WIDTH-1:0]) : rem_r[WIDTH-1:0];
        rem_fix  = a_neg ? (~rem_mag + 1'b1) : rem_mag;
        quot_fix = (a_neg ^ b_neg) ? (~quo_r + 1'b1) : quo_r;
    end

    // Sequencer: state and iteration counter
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt <= '0;
                        if (!op)
                            state <= S_MUL;
                        else if (b_in == '0)
                            state <= S_DZ;
                        else
                            state <= S_DIV;
                    end
                end
                S_MUL: begin
                    if (cnt == CW'(MUL_ITERS))
                        state <= S_DONE;
                    else
                        cnt <= cnt + CW'(1);
                end
                S_DIV: begin
                    if (cnt == CW'(WIDTH))
                        state <= S_DFIX;
                    else
                        cnt <= cnt + CW'(1);
                end
                S_DFIX: state <= S_DONE;
                S_DZ: begin
                    if (cnt == CW'(1))
                        state <= S_DONE;
                    else
                        cnt <= cnt + CW'(1);
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Operand capture and the per-step multiply/divide registers
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            prod    <= '0;
            m_sh    <= '0;
            mq      <= '0;
            mq_prev <= 1'b0;
            rem_r   <= '0;
            dvs     <= '0;
            quo_r   <= '0;
            a_neg   <= 1'b0;
            b_neg   <= 1'b0;
            a_reg   <= '0;
        end else if (accept) begin
            prod    <= '0;
            m_sh    <= {{(PW-WIDTH){a_in[WIDTH-1]}}, a_in};
            mq      <= b_in;
            mq_prev <= 1'b0;
            rem_r   <= '0;
            dvs     <= {2'b00, b_mag};
            quo_r   <= a_mag;
            a_neg   <= a_in[WIDTH-1];
            b_neg   <= b_in[WIDTH-1];
            a_reg   <= a_in;
        end else if (mul_step) begin
            prod    <= prod + pp;
            m_sh    <= m_sh << 2;
            mq      <= mq >> 2;
            mq_prev <= mq[1];
        end else if (div_step) begin
            rem_r   <= r_next;
            quo_r   <= q_next;
        end
    end

    // Visible results: written only on entry to DONE; flag cleared on accept
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            result_hi <= '0;
            result_lo <= '0;
            dz_r      <= 1'b0;
        end else begin
            if (accept)
                dz_r <= 1'b0;
            if (mul_last) begin
                result_hi <= prod[2*WIDTH-1:WIDTH];
                result_lo <= prod[WIDTH-1:0];
            end else if (state == S_DFIX) begin
                result_hi <= rem_fix;
                result_lo <= quot_fix;
            end else if (dz_last) begin
                result_hi <= a_reg;
                result_lo <= '1;
                dz_r      <= 1'b1;
            end
        end
    end

endmodule
